// File: rtl/rom_prefetch_buffer_if.sv
// Fetch-side bundle of the ROM prefetcher: redirect request plus the
// instruction valid/ready stream. The buffer sits on the slave side and
// the instruction-fetch consumer sits on the master side.
interface rom_prefetch_buffer_if #(
  parameter int AW = 13
);
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_addr;

  modport master (
    output flush, flush_addr, instr_ready,
    input  instr_valid, instr_data, instr_addr
  );

  modport slave (
    input  flush, flush_addr, instr_ready,
    output instr_valid, instr_data, instr_addr
  );
endinterface

// File: rtl/rom_prefetch_buffer.sv
// Sequential prefetcher for a synchronous-read ROM.
//
// Consecutive words are streamed into a DEPTH-entry FIFO. A read is issued
// only when there is guaranteed room for it: the buffered words plus the
// single in-flight read must be below DEPTH. A pop in the same cycle is not
// credited, so a free slot is always waiting when the ROM data comes back.
// A flush clears everything and restarts the stream at flush_addr.
module rom_prefetch_buffer #(
  parameter  int MEM_WORDS = 8192,
  parameter  int DEPTH     = 4,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic           CLK,
  input  logic           RST,
  output logic           ROM_EN,
  output logic [AW-1:0]  ROM_A,
  input  logic [31:0]    ROM_DO,
  rom_prefetch_buffer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } entry_t;

  logic [AW-1:0] pf_addr;
  logic          inflight;
  logic [AW-1:0] inflight_addr;
  entry_t        fifo [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [AW-1:0] pf_addr_inc;
  entry_t        head;

  // Credit check, push/pop qualification and the registered ROM address.
  always_comb begin
    occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue       = !RST && !bus.flush && (occupancy < (CW+1)'(DEPTH));
    pf_addr_inc = (pf_addr == AW'(MEM_WORDS - 1)) ? '0 : pf_addr + AW'(1);
    push        = inflight && !bus.flush;
    pop         = bus.instr_valid && bus.instr_ready;
    ROM_EN      = issue;
    ROM_A       = pf_addr;
  end

  // Consumer-facing head; zeroed whenever nothing is presented.
  always_comb begin
    head            = fifo[rptr];
    bus.instr_valid = (count != '0) && !bus.flush;
    bus.instr_data  = bus.instr_valid ? head.data : '0;
    bus.instr_addr  = bus.instr_valid ? head.addr : '0;
  end

  // Issue side: next address to fetch and the read currently in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pf_addr       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (bus.flush) begin
      pf_addr  <= bus.flush_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pf_addr       <= pf_addr_inc;
        inflight_addr <= pf_addr;
      end
    end
  end

  // FIFO bookkeeping; flush and reset both empty it.
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage: ROM data is only sampled when a read was actually in flight.
  always_ff @(posedge CLK) begin
    if (!RST && push) fifo[wptr] <= '{data: ROM_DO, addr: inflight_addr};
  end

`ifndef SYNTHESIS
  // The issue credit must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (count == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Self-checking bench for rom_prefetch_buffer with a behavioural ROM
// (word[i] = 0xA000_0000 + i, one-cycle read latency, 0 when disabled).
module tb_rom_prefetch_buffer;
  localparam int MEM_WORDS = 8192;
  localparam int DEPTH     = 4;
  localparam int AW        = $clog2(MEM_WORDS);

  logic          CLK = 1'b0;
  logic          RST;
  logic          ROM_EN;
  logic [AW-1:0] ROM_A;
  logic [31:0]   ROM_DO = '0;

  rom_prefetch_buffer_if #(.AW(AW)) bus ();

  rom_prefetch_buffer #(.MEM_WORDS(MEM_WORDS), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ROM_EN (ROM_EN),
    .ROM_A  (ROM_A),
    .ROM_DO (ROM_DO),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + {{(32-AW){1'b0}}, a};
  endfunction

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (a == AW'(MEM_WORDS - 1)) ? '0 : a + AW'(1);
  endfunction

  // ROM model: samples EN/A on the edge, returns data one cycle later.
  always @(posedge CLK) ROM_DO <= ROM_EN ? rom_word(ROM_A) : 32'h0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q [$];

  task automatic do_reset();
    RST = 1'b1;
    bus.flush = 1'b0;
    bus.flush_addr = '0;
    bus.instr_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_chk++; if (ROM_EN !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %0h expected 0", ROM_EN); end
    n_chk++; if (ROM_A !== '0) begin n_fail++; $display("FAIL reset_rom_a: got %0h expected 0", ROM_A); end
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", bus.instr_valid); end
    n_chk++; if (bus.instr_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", bus.instr_data); end
    n_chk++; if (bus.instr_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", bus.instr_addr); end
  endtask

  task automatic test_stream();
    int first_en = -1, first_v = -1, iss = 0;
    logic [AW-1:0] e;
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(AW'(i));
    RST = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      if (ROM_EN) begin
        if (first_en < 0) begin
          first_en = c;
          n_chk++; if (c != 0) begin n_fail++; $display("FAIL stream_first_issue: got cycle %0d expected 0", c); end
        end
        n_chk++; if (ROM_A !== AW'(iss)) begin n_fail++; $display("FAIL stream_rom_a: got %0h expected %0h", ROM_A, iss); end
        iss++;
      end
      if (bus.instr_valid) begin
        if (first_v < 0) begin
          first_v = c;
          n_chk++; if (first_v != first_en + 2) begin n_fail++; $display("FAIL stream_latency: got cycle %0d expected %0d", first_v, first_en + 2); end
        end
        e = exp_q.pop_front();
        n_chk++; if (bus.instr_addr !== e) begin n_fail++; $display("FAIL stream_addr: got %0h expected %0h", bus.instr_addr, e); end
        n_chk++; if (bus.instr_data !== rom_word(e)) begin n_fail++; $display("FAIL stream_data: got %0h expected %0h", bus.instr_data, rom_word(e)); end
      end else if (first_v >= 0) begin
        n_chk++; n_fail++; $display("FAIL stream_gap: got valid 0 expected 1 at cycle %0d", c);
      end
      @(posedge CLK); #1;
    end
    n_chk++; if (first_v < 0) begin n_fail++; $display("FAIL stream_timeout: got no valid expected delivery"); end
  endtask

  task automatic test_backpressure();
    int iss = 0, guard = 0;
    bit resumed = 0;
    logic [AW-1:0] e;
    do_reset();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (ROM_EN) begin
        n_chk++; if (ROM_A !== AW'(iss)) begin n_fail++; $display("FAIL bp_rom_a: got %0h expected %0h", ROM_A, iss); end
        iss++;
      end
      if (c == 9) begin
        n_chk++; if (ROM_EN !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %0h expected 0", ROM_EN); end
      end
      @(posedge CLK); #1;
    end
    n_chk++; if (iss != DEPTH) begin n_fail++; $display("FAIL bp_issue_count: got %0d expected %0d", iss, DEPTH); end
    for (int i = 0; i < 10; i++) exp_q.push_back(AW'(i));
    bus.instr_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge CLK);
      if (ROM_EN && !resumed) begin
        resumed = 1;
        n_chk++; if (ROM_A !== AW'(4)) begin n_fail++; $display("FAIL bp_resume_addr: got %0h expected 4", ROM_A); end
      end
      if (bus.instr_valid) begin
        e = exp_q.pop_front();
        n_chk++; if (bus.instr_addr !== e) begin n_fail++; $display("FAIL bp_addr: got %0h expected %0h", bus.instr_addr, e); end
        n_chk++; if (bus.instr_data !== rom_word(e)) begin n_fail++; $display("FAIL bp_data: got %0h expected %0h", bus.instr_data, rom_word(e)); end
      end
      guard++;
      @(posedge CLK); #1;
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    int guard = 0;
    logic [AW-1:0] e;
    do_reset();
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    // Three words buffered, one in flight.
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(13'h100 + i));
    bus.flush = 1'b1;
    bus.flush_addr = AW'(13'h100);
    bus.instr_ready = 1'b1;
    @(negedge CLK);
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_pop: got valid %0h expected 0", bus.instr_valid); end
    n_chk++; if (ROM_EN !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue: got %0h expected 0", ROM_EN); end
    @(posedge CLK); #1;
    bus.flush = 1'b0;
    for (int c = 1; exp_q.size() != 0 && c < 20; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        n_chk++; if (ROM_EN !== 1'b1 || ROM_A !== AW'(13'h100)) begin n_fail++; $display("FAIL flush_reissue: got en=%0h a=%0h expected en=1 a=100", ROM_EN, ROM_A); end
      end
      if (c < 3) begin
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid: got 1 expected 0 at f+%0d", c); end
      end
      if (c == 3) begin
        n_chk++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_f3_valid: got %0h expected 1", bus.instr_valid); end
      end
      if (bus.instr_valid) begin
        e = exp_q.pop_front();
        n_chk++; if (bus.instr_addr !== e) begin n_fail++; $display("FAIL flush_addr: got %0h expected %0h", bus.instr_addr, e); end
        n_chk++; if (bus.instr_data !== rom_word(e)) begin n_fail++; $display("FAIL flush_data: got %0h expected %0h", bus.instr_data, rom_word(e)); end
      end
      guard = c;
      @(posedge CLK); #1;
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_timeout: got %0d left expected 0 after %0d", exp_q.size(), guard); end
  endtask

  task automatic test_wrap();
    int guard = 0;
    logic [AW-1:0] e;
    exp_q.delete();
    exp_q.push_back(AW'(13'h1FFE));
    exp_q.push_back(AW'(13'h1FFF));
    exp_q.push_back(AW'(0));
    exp_q.push_back(AW'(1));
    bus.instr_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_addr = AW'(MEM_WORDS - 2);
    @(posedge CLK); #1;
    bus.flush = 1'b0;
    while (exp_q.size() != 0 && guard < 12) begin
      @(negedge CLK);
      if (bus.instr_valid) begin
        e = exp_q.pop_front();
        n_chk++; if (bus.instr_addr !== e) begin n_fail++; $display("FAIL wrap_addr: got %0h expected %0h", bus.instr_addr, e); end
        n_chk++; if (bus.instr_data !== rom_word(e)) begin n_fail++; $display("FAIL wrap_data: got %0h expected %0h", bus.instr_data, rom_word(e)); end
      end
      guard++;
      @(posedge CLK); #1;
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_midreset();
    int guard = 0;
    logic [AW-1:0] e;
    exp_q.delete();
    bus.instr_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_addr = AW'(13'h0A0);
    @(posedge CLK); #1;
    bus.flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_chk++; if (ROM_EN !== 1'b0) begin n_fail++; $display("FAIL mrst_rom_en: got %0h expected 0", ROM_EN); end
    n_chk++; if (ROM_A !== '0) begin n_fail++; $display("FAIL mrst_rom_a: got %0h expected 0", ROM_A); end
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0h expected 0", bus.instr_valid); end
    n_chk++; if (bus.instr_data !== '0 || bus.instr_addr !== '0) begin n_fail++; $display("FAIL mrst_head: got %0h/%0h expected 0/0", bus.instr_data, bus.instr_addr); end
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    @(posedge CLK); #1;
    RST = 1'b0;
    while (exp_q.size() != 0 && guard < 15) begin
      @(negedge CLK);
      if (bus.instr_valid) begin
        e = exp_q.pop_front();
        n_chk++; if (bus.instr_addr !== e) begin n_fail++; $display("FAIL mrst_addr: got %0h expected %0h", bus.instr_addr, e); end
        n_chk++; if (bus.instr_data !== rom_word(e)) begin n_fail++; $display("FAIL mrst_data: got %0h expected %0h", bus.instr_data, rom_word(e)); end
      end
      guard++;
      @(posedge CLK); #1;
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mrst_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_next = '0;
    int n_del = 0;
    do_reset();
    RST = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 31) == 0);
      if (bus.flush) begin
        bus.flush_addr = AW'($urandom_range(0, MEM_WORDS - 1));
        exp_next = bus.flush_addr;
      end
      @(negedge CLK);
      if (bus.flush && bus.instr_valid) begin
        n_chk++; n_fail++; $display("FAIL rnd_valid_in_flush: got 1 expected 0 at cycle %0d", c);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        n_chk++; if (bus.instr_addr !== exp_next) begin n_fail++; $display("FAIL rnd_addr: got %0h expected %0h at cycle %0d", bus.instr_addr, exp_next, c); end
        n_chk++; if (bus.instr_data !== rom_word(exp_next)) begin n_fail++; $display("FAIL rnd_data: got %0h expected %0h at cycle %0d", bus.instr_data, rom_word(exp_next), c); end
        exp_next = nxt(exp_next);
        n_del++;
      end
      @(posedge CLK); #1;
    end
    bus.flush = 1'b0;
    n_chk++; if (n_del < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries expected at least 200", n_del); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end
endmodule
